// File: rtl/wb_commit_stage.sv
// Write-back / commit stage for an in-order multi-lane pipeline.
// Holds one bundle of NLANE instructions. It commits the lanes in order up to
// the first lane that carries an exception or an eret, and raises a single
// CP0 pulse for that lane. After such a pulse the stage discards incoming
// bundles for FLUSH_CYC cycles.
// The rf_* and wb_* outputs are decoded only from the held bundle registers
// and ws_hold, so the ms_* inputs never reach them combinationally.
module wb_commit_stage #(
    parameter int NLANE     = 2,
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int FLUSH_CYC = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ms_to_ws_valid,
    input  logic [NLANE-1:0]    ms_lane_v,
    input  logic [NLANE-1:0]    ms_gr_we,
    input  logic [NLANE*AW-1:0] ms_dest,
    input  logic [NLANE*DW-1:0] ms_result,
    input  logic [NLANE*32-1:0] ms_pc,
    input  logic [NLANE-1:0]    ms_ex,
    input  logic [NLANE*5-1:0]  ms_excode,
    input  logic [NLANE-1:0]    ms_eret,
    input  logic                ws_hold,
    output logic                ws_allowin,
    output logic [NLANE-1:0]    rf_we,
    output logic [NLANE*AW-1:0] rf_waddr,
    output logic [NLANE*DW-1:0] rf_wdata,
    output logic                wb_ex,
    output logic [4:0]          wb_excode,
    output logic [31:0]         wb_pc,
    output logic                eret_flush,
    output logic [31:0]         retire_cnt
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYC);

    // Number of set bits in a lane mask.
    function automatic logic [2:0] popcount(input logic [NLANE-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NLANE; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    state_e              state_r;
    logic [2:0]          flush_cnt_r;
    logic                ws_valid_r;
    logic [NLANE-1:0]    lane_v_r;
    logic [NLANE-1:0]    gr_we_r;
    logic [NLANE*AW-1:0] dest_r;
    logic [NLANE*DW-1:0] result_r;
    logic [NLANE*32-1:0] pc_r;
    logic [NLANE-1:0]    ex_r;
    logic [NLANE*5-1:0]  excode_r;
    logic [NLANE-1:0]    eret_r;
    logic [31:0]         retire_cnt_r;

    logic [NLANE-1:0]    stop_lane_s;
    logic [NLANE-1:0]    onehot_s;
    logic [NLANE-1:0]    below_s;
    logic                found_s;
    logic [4:0]          sel_excode_s;
    logic [31:0]         sel_pc_s;
    logic                stop_ex_s;
    logic                stop_eret_s;
    logic                commit_s;
    logic                flush_go_s;
    logic                load_s;
    logic [31:0]         retire_add_s;

    assign stop_lane_s = lane_v_r & (ex_r | eret_r);
    assign stop_ex_s   = |(onehot_s & ex_r);
    assign stop_eret_s = |(onehot_s & eret_r & ~ex_r);
    assign commit_s    = ws_valid_r & ~ws_hold;
    assign flush_go_s  = commit_s & (stop_ex_s | stop_eret_s);
    assign load_s      = (state_r == ST_RUN) & ms_to_ws_valid & ws_allowin & ~flush_go_s;
    assign retire_add_s = 32'(popcount(lane_v_r & below_s)) + 32'(stop_eret_s);
    assign retire_cnt  = retire_cnt_r;

    // Locate the oldest stopping lane: one-hot marker plus the mask of lanes older than it.
    always_comb begin
        found_s  = 1'b0;
        onehot_s = '0;
        below_s  = '0;
        for (int i = 0; i < NLANE; i++) begin
            onehot_s[i] = stop_lane_s[i] & ~found_s;
            below_s[i]  = ~found_s & ~stop_lane_s[i];
            found_s     = found_s | stop_lane_s[i];
        end
    end

    // Pick the excode and PC of the stopping lane.
    always_comb begin
        sel_excode_s = 5'd0;
        sel_pc_s     = 32'd0;
        for (int i = 0; i < NLANE; i++) begin
            sel_excode_s = sel_excode_s | (excode_r[i*5 +: 5] & {5{onehot_s[i]}});
            sel_pc_s     = sel_pc_s | (pc_r[i*32 +: 32] & {32{onehot_s[i]}});
        end
    end

    // Drive the commit outputs from the held bundle, all zero unless committing.
    always_comb begin
        rf_we    = lane_v_r & gr_we_r & below_s & {NLANE{commit_s}};
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < NLANE; i++) begin
            rf_waddr[i*AW +: AW] = dest_r[i*AW +: AW] & {AW{rf_we[i]}};
            rf_wdata[i*DW +: DW] = result_r[i*DW +: DW] & {DW{rf_we[i]}};
        end
        wb_ex      = commit_s & stop_ex_s;
        eret_flush = commit_s & stop_eret_s;
        wb_excode  = sel_excode_s & {5{wb_ex}};
        wb_pc      = sel_pc_s & {32{wb_ex}};
        ws_allowin = (state_r == ST_FLUSH) | ~ws_valid_r | ~ws_hold;
    end

    // Bundle payload registers, captured when a bundle is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_v_r <= '0;
            gr_we_r  <= '0;
            dest_r   <= '0;
            result_r <= '0;
            pc_r     <= '0;
            ex_r     <= '0;
            excode_r <= '0;
            eret_r   <= '0;
        end else if (load_s) begin
            lane_v_r <= ms_lane_v;
            gr_we_r  <= ms_gr_we;
            dest_r   <= ms_dest;
            result_r <= ms_result;
            pc_r     <= ms_pc;
            ex_r     <= ms_ex;
            excode_r <= ms_excode;
            eret_r   <= ms_eret;
        end
    end

    // Bundle-present flag: cleared by a flush or by a commit without a new load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_r <= 1'b0;
        end else if (flush_go_s) begin
            ws_valid_r <= 1'b0;
        end else if (load_s) begin
            ws_valid_r <= 1'b1;
        end else if (commit_s) begin
            ws_valid_r <= 1'b0;
        end
    end

    // Run/flush sequencer with the discard-cycle counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (flush_go_s) begin
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= FLUSH_CNT;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_r <= flush_cnt_r - 3'd1;
                    if (flush_cnt_r == 3'd1) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r     <= ST_RUN;
                    flush_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // Retired-lane counter, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retire_cnt_r <= 32'd0;
        end else if (commit_s) begin
            retire_cnt_r <= retire_cnt_r + retire_add_s;
        end
    end

endmodule
